out_fifo_mr: RTL and testbench
==============================

OUT_FIFO_MR -- requirements
Module: out_fifo_mr

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning entry width in bits.
REQ-002 SHALL have parameter BufferWidth, default 4, meaning log2 of depth; depth D = 2**BufferWidth (power of two only).
REQ-003 SHALL have parameter NumReaders, default 2, meaning number of independent read ports (1..8).
REQ-004 SHALL have parameter AFullLevel, default D-2, meaning almost_full threshold in entries.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port aclr, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port clk_en, input, 1, meaning global enable; when 0 all state holds.
REQ-008 SHALL have port push, input, 1, meaning write request.
REQ-009 SHALL have port data_in, input, DataWidth, meaning write data.
REQ-010 SHALL have port pop, input, NumReaders, meaning per-reader read-advance request.
REQ-011 SHALL have port data_out, output, NumReaders*DataWidth, meaning per-reader head data, reader r in slice r.
REQ-012 SHALL have port full, input-side flag, output, 1, meaning no free slot for the writer.
REQ-013 SHALL have port almost_full, output, 1, meaning writer occupancy >= AFullLevel.
REQ-014 SHALL have port empty, output, NumReaders, meaning reader r has no unread entry.
REQ-015 SHALL have port ready, output, NumReaders*D, meaning per-reader slot mask: bit i set when slot i holds data unread by reader r.
REQ-016 SHALL have port overflow, output, 1, meaning sticky: push rejected while full.
REQ-017 SHALL have port underflow, output, NumReaders, meaning sticky per reader: pop rejected while empty.

Function
REQ-018 SHALL keep wr_ptr and one rd_ptr per reader, each BufferWidth+1 bits; MSB is the wrap (round) bit.
REQ-019 SHALL compute per-reader count_r = wr_ptr - rd_ptr[r] modulo 2**(BufferWidth+1), range 0..D.
REQ-020 SHALL define writer occupancy as max over r of count_r (slot freed only when every reader consumed it).
REQ-021 SHALL assert full when occupancy == D, almost_full when occupancy >= AFullLevel, empty[r] when count_r == 0; all combinational from registered pointers.
REQ-022 SHALL accept push when clk_en & push & !full: write data_in to mem[wr_ptr low bits], increment wr_ptr.
REQ-023 SHALL accept pop[r] when clk_en & pop[r] & !empty[r]: increment rd_ptr[r]; readers advance independently.
REQ-024 SHALL drive data_out slice r combinationally as mem[rd_ptr[r] low bits] (show-ahead, zero latency); value is don't-care when empty[r].
REQ-025 SHALL evaluate full/empty from pre-edge state: push while full is rejected even with same-cycle pop; pop while empty is rejected even with same-cycle push.
REQ-026 SHALL, on simultaneous accepted push and pop, update both pointers; count_r unchanged for that reader.
REQ-027 SHALL set overflow on a rejected push and underflow[r] on a rejected pop[r]; cleared only by reset.
REQ-028 SHALL set ready bit i of reader r when slot i lies in [rd_ptr[r], wr_ptr) modulo D, including wrapped ranges; all ones when count_r == D.
REQ-029 SHALL wrap pointers naturally from 2**(BufferWidth+1)-1 to 0 with no special casing.

Reset
REQ-030 SHALL on aclr low immediately clear wr_ptr, all rd_ptr, overflow, underflow; full=0, almost_full=0 (unless AFullLevel==0), empty all 1, ready all 0.
REQ-031 SHALL leave memory contents uninitialised; reset mid-operation discards all entries.
REQ-032 SHALL ignore push/pop in the cycle aclr deasserts only if aclr is still low at the edge.

Structure
REQ-033 SHALL place shared constants (max NumReaders, default widths) and a pointer-difference function in package fifo_pkg.
REQ-034 SHALL implement per-reader pointer, count, empty, underflow and ready mask in sub-module fifo_rd_port, instantiated NumReaders times in a generate loop.
REQ-035 SHALL implement storage as a flat register array with one write port and NumReaders asynchronous read ports.

Verification
REQ-036 SHALL cover fill: D=16, 16 pushes no pops -> full=1 after 16th, 17th push rejected, overflow=1, data unchanged.
REQ-037 SHALL cover slow reader: push 16, reader0 pops 16, reader1 pops 0 -> empty[0]=1, full remains 1 until reader1 pops, then full=0.
REQ-038 SHALL cover wrap: 40 push/pop pairs interleaved -> every pop returns data in push order, pointers wrap past 31 to 0, ready masks correct across wrap.
REQ-039 SHALL cover simultaneous push+pop at count 16 -> push rejected, pop accepted, count 15; at count 0 -> pop rejected, underflow[r]=1, count 1.
REQ-040 SHALL cover reset mid-stream: aclr low with 7 entries -> empty all 1, ready all 0, overflow/underflow 0 without waiting for clk.
REQ-041 SHALL cover clk_en=0 with push and pop asserted for 5 cycles -> no pointer or flag change.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and pointer arithmetic for the multi-reader output FIFO.
package fifo_pkg;

    localparam int unsigned MaxReaders     = 8;
    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefBufferWidth = 4;

    // Modular difference a - b over ptr_w-bit wrap-tagged pointers; yields the entry count.
    function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                             input int unsigned ptr_w);
        int unsigned mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/fifo_rd_port.sv
// One independent reader: read pointer, count, empty, sticky underflow and slot-ready mask.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int unsigned BufferWidth = DefBufferWidth
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        clk_en,
    input  logic                        pop,
    input  logic [BufferWidth:0]        wr_ptr,
    output logic [BufferWidth-1:0]      rd_addr,
    output logic [BufferWidth:0]        count,
    output logic                        empty,
    output logic                        underflow,
    output logic [2**BufferWidth-1:0]   ready
);

    localparam int unsigned PtrW  = BufferWidth + 1;
    localparam int unsigned Depth = 2 ** BufferWidth;

    logic [BufferWidth:0]   rd_ptr;
    logic [BufferWidth-1:0] offset;
    logic                   pop_ok;

    assign count   = PtrW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PtrW));
    assign empty   = (count == '0);
    assign rd_addr = rd_ptr[BufferWidth-1:0];
    // Empty is judged from pre-edge state, so a same-cycle push cannot rescue a pop.
    assign pop_ok  = clk_en & pop & ~empty;

    // Read pointer advance and sticky underflow.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            rd_ptr    <= '0;
            underflow <= 1'b0;
        end else if (clk_en) begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Slot i is unread when its distance past the read address is below the count.
    always_comb begin
        ready  = '0;
        offset = '0;
        for (int i = 0; i < Depth; i++) begin
            offset   = BufferWidth'(i) - rd_addr;
            ready[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/out_fifo_mr.sv
// Single-writer, multi-reader FIFO with show-ahead reads; a slot frees once all readers pass it.
module out_fifo_mr
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned BufferWidth = DefBufferWidth,
    parameter int unsigned NumReaders  = 2,
    parameter int unsigned AFullLevel  = (2 ** BufferWidth) - 2
) (
    input  logic                                clk,
    input  logic                                aclr,
    input  logic                                clk_en,
    input  logic                                push,
    input  logic [DataWidth-1:0]                data_in,
    input  logic [NumReaders-1:0]               pop,
    output logic [NumReaders*DataWidth-1:0]     data_out,
    output logic                                full,
    output logic                                almost_full,
    output logic [NumReaders-1:0]               empty,
    output logic [NumReaders*(2**BufferWidth)-1:0] ready,
    output logic                                overflow,
    output logic [NumReaders-1:0]               underflow
);

    localparam int unsigned Depth = 2 ** BufferWidth;
    localparam int unsigned PtrW  = BufferWidth + 1;

    logic [DataWidth-1:0]   mem [Depth];
    logic [BufferWidth:0]   wr_ptr;
    logic [BufferWidth:0]   count   [NumReaders];
    logic [BufferWidth-1:0] rd_addr [NumReaders];
    logic [BufferWidth:0]   occupancy;
    logic                   push_ok;

    // Writer occupancy is set by the slowest reader.
    always_comb begin
        occupancy = '0;
        for (int r = 0; r < NumReaders; r++) begin
            if (count[r] > occupancy) begin
                occupancy = count[r];
            end
        end
    end

    assign full        = (occupancy == PtrW'(Depth));
    assign almost_full = (32'(occupancy) >= AFullLevel);
    assign push_ok     = clk_en & push & ~full;

    // Write pointer advance and sticky overflow.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clk_en) begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[BufferWidth-1:0]] <= data_in;
        end
    end

    for (genvar r = 0; r < NumReaders; r++) begin : g_rd
        fifo_rd_port #(
            .BufferWidth (BufferWidth)
        ) u_port (
            .clk       (clk),
            .aclr      (aclr),
            .clk_en    (clk_en),
            .pop       (pop[r]),
            .wr_ptr    (wr_ptr),
            .rd_addr   (rd_addr[r]),
            .count     (count[r]),
            .empty     (empty[r]),
            .underflow (underflow[r]),
            .ready     (ready[r*Depth +: Depth])
        );

        assign data_out[r*DataWidth +: DataWidth] = mem[rd_addr[r]];
    end

endmodule

// File: tb/tb_out_fifo_mr.sv
// Randomized bench for out_fifo_mr against a queue-based reference model.
module tb_out_fifo_mr;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NR = 2;
    localparam int D  = 16;
    localparam int AF = 14;

    logic              clk = 1'b0;
    logic              aclr = 1'b0;
    logic              clk_en = 1'b1;
    logic              push = 1'b0;
    logic [DW-1:0]     data_in = '0;
    logic [NR-1:0]     pop = '0;
    logic [NR*DW-1:0]  data_out;
    logic              full;
    logic              almost_full;
    logic [NR-1:0]     empty;
    logic [NR*D-1:0]   ready;
    logic              overflow;
    logic [NR-1:0]     underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: absolute push/pop totals and the full push history.
    logic [DW-1:0] hist[$];
    int            m_wr;
    int            m_rd[NR];
    logic          m_ovf;
    logic [NR-1:0] m_unf;

    out_fifo_mr #(
        .DataWidth   (DW),
        .BufferWidth (BW),
        .NumReaders  (NR),
        .AFullLevel  (AF)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .clk_en      (clk_en),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .ready       (ready),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt(input int r);
        return m_wr - m_rd[r];
    endfunction

    function automatic int m_occ();
        int o = 0;
        for (int r = 0; r < NR; r++) if (m_cnt(r) > o) o = m_cnt(r);
        return o;
    endfunction

    function automatic logic [NR-1:0] m_empty();
        logic [NR-1:0] e;
        for (int r = 0; r < NR; r++) e[r] = (m_cnt(r) == 0);
        return e;
    endfunction

    function automatic logic [NR*D-1:0] m_ready();
        logic [NR*D-1:0] m = '0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < m_cnt(r); k++) m[r*D + ((m_rd[r] + k) % D)] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] dout(input int r);
        return data_out[r*DW +: DW];
    endfunction

    task automatic model_clear();
        hist.delete();
        m_wr = 0;
        for (int r = 0; r < NR; r++) m_rd[r] = 0;
        m_ovf = 1'b0;
        m_unf = '0;
    endtask

    // Drive one cycle; model decisions use pre-edge state.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic [NR-1:0] pp,
                        input logic en);
        logic          acc_push;
        logic [NR-1:0] acc_pop;
        push = p; data_in = d; pop = pp; clk_en = en;
        acc_push = en && p && (m_occ() < D);
        if (en && p && (m_occ() == D)) m_ovf = 1'b1;
        for (int r = 0; r < NR; r++) begin
            acc_pop[r] = en && pp[r] && (m_cnt(r) > 0);
            if (en && pp[r] && (m_cnt(r) == 0)) m_unf[r] = 1'b1;
        end
        @(posedge clk);
        if (acc_push) begin
            hist.push_back(d);
            m_wr++;
        end
        for (int r = 0; r < NR; r++) if (acc_pop[r]) m_rd[r]++;
        #1;
        push = 1'b0; pop = '0; clk_en = 1'b1;
    endtask

    task automatic do_reset();
        #2 aclr = 1'b0;
        model_clear();
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        model_clear();
        n_cmp++;
        if (empty !== '1 || full !== 1'b0 || almost_full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got empty=%b full=%b af=%b, need empty=11 full=0 af=0",
                     empty, full, almost_full);
        end
        n_cmp++;
        if (ready !== '0 || overflow !== 1'b0 || underflow !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got ready=%h ovf=%b unf=%b, need all zero",
                     ready, overflow, underflow);
        end
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= D; i++) begin
            step(1'b1, $urandom, '0, 1'b1);
            n_cmp++;
            if (full !== (i == D) || almost_full !== (i >= AF)) begin
                n_bad++;
                $display("FAIL fill_flags[%0d]: got full=%b af=%b, need full=%b af=%b",
                         i, full, almost_full, i == D, i >= AF);
            end
            n_cmp++;
            if (ready !== m_ready()) begin
                n_bad++;
                $display("FAIL fill_ready[%0d]: got %h need %h", i, ready, m_ready());
            end
        end
        step(1'b1, 32'hDEAD_BEEF, '0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1 || full !== 1'b1 || m_wr != D) begin
            n_bad++;
            $display("FAIL fill_overflow: got ovf=%b full=%b, need ovf=1 full=1", overflow, full);
        end
        n_cmp++;
        if (dout(0) !== hist[0] || dout(1) !== hist[0]) begin
            n_bad++;
            $display("FAIL fill_head: got %h/%h need %h", dout(0), dout(1), hist[0]);
        end
    endtask

    task automatic test_slow_reader();
        for (int k = 0; k < D; k++) begin
            n_cmp++;
            if (dout(0) !== hist[k]) begin
                n_bad++;
                $display("FAIL slow_data0[%0d]: got %h need %h", k, dout(0), hist[k]);
            end
            step(1'b0, '0, 2'b01, 1'b1);
        end
        n_cmp++;
        if (empty !== 2'b01 || full !== 1'b1 || ready !== m_ready()) begin
            n_bad++;
            $display("FAIL slow_lagging: got empty=%b full=%b ready=%h, need 01 1 %h",
                     empty, full, ready, m_ready());
        end
        step(1'b0, '0, 2'b10, 1'b1);
        n_cmp++;
        if (full !== 1'b0 || dout(1) !== hist[1]) begin
            n_bad++;
            $display("FAIL slow_release: got full=%b d1=%h, need 0 %h", full, dout(1), hist[1]);
        end
        while (m_cnt(1) > 0) step(1'b0, '0, 2'b10, 1'b1);
        n_cmp++;
        if (empty !== 2'b11 || underflow !== 2'b00) begin
            n_bad++;
            $display("FAIL slow_drained: got empty=%b unf=%b need 11 00", empty, underflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, '0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (dout(0) !== hist[m_rd[0]] || dout(1) !== hist[m_rd[1]]) begin
                n_bad++;
                $display("FAIL wrap_data[%0d]: got %h/%h need %h/%h", i, dout(0), dout(1),
                         hist[m_rd[0]], hist[m_rd[1]]);
            end
            n_cmp++;
            if (ready !== m_ready()) begin
                n_bad++;
                $display("FAIL wrap_ready[%0d]: got %h need %h", i, ready, m_ready());
            end
            step(1'b1, $urandom, 2'b11, 1'b1);
        end
    endtask

    task automatic test_simul();
        while (m_occ() < D) step(1'b1, $urandom, '0, 1'b1);
        step(1'b1, $urandom, 2'b11, 1'b1);
        n_cmp++;
        if (full !== 1'b0 || m_cnt(0) != D - 1 || ready !== m_ready() || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_full: got full=%b ovf=%b ready=%h, need 0 1 %h",
                     full, overflow, ready, m_ready());
        end
        while (m_cnt(0) > 0) step(1'b0, '0, 2'b11, 1'b1);
        step(1'b1, 32'h1234_5678, 2'b11, 1'b1);
        n_cmp++;
        if (underflow !== 2'b11 || empty !== 2'b00 || ready !== m_ready()) begin
            n_bad++;
            $display("FAIL simul_empty: got unf=%b empty=%b ready=%h, need 11 00 %h",
                     underflow, empty, ready, m_ready());
        end
        n_cmp++;
        if (dout(0) !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL simul_head: got %h need 12345678", dout(0));
        end
    endtask

    task automatic test_clk_en();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, '0, 1'b1);
        step(1'b0, '0, 2'b01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, 2'b11, 1'b0);
            n_cmp++;
            if (ready !== m_ready() || empty !== m_empty() || full !== 1'b0 ||
                dout(0) !== hist[m_rd[0]] || dout(1) !== hist[m_rd[1]]) begin
                n_bad++;
                $display("FAIL clk_en_hold[%0d]: got ready=%h empty=%b, need %h %b",
                         i, ready, empty, m_ready(), m_empty());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, '0, 1'b1);
        step(1'b1, '0, 2'b00, 1'b1);
        step(1'b0, '0, 2'b11, 1'b1);
        #2 aclr = 1'b0;
        #1;
        model_clear();
        n_cmp++;
        if (empty !== 2'b11 || ready !== '0 || overflow !== 1'b0 || underflow !== '0 ||
            full !== 1'b0 || almost_full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got empty=%b ready=%h ovf=%b unf=%b full=%b",
                     empty, ready, overflow, underflow, full);
        end
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), $urandom, NR'($urandom),
                 ($urandom_range(0, 9) != 0));
            n_cmp++;
            if (full !== (m_occ() == D) || almost_full !== (m_occ() >= AF) ||
                empty !== m_empty() || ready !== m_ready() ||
                overflow !== m_ovf || underflow !== m_unf) begin
                n_bad++;
                $display("FAIL random_flags[%0d]: got f=%b af=%b e=%b rdy=%h o=%b u=%b need %b %b %b %h %b %b",
                         i, full, almost_full, empty, ready, overflow, underflow,
                         m_occ() == D, m_occ() >= AF, m_empty(), m_ready(), m_ovf, m_unf);
            end
            for (int r = 0; r < NR; r++) begin
                if (m_cnt(r) > 0) begin
                    n_cmp++;
                    if (dout(r) !== hist[m_rd[r]]) begin
                        n_bad++;
                        $display("FAIL random_data[%0d] r%0d: got %h need %h",
                                 i, r, dout(r), hist[m_rd[r]]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_slow_reader();
        test_wrap();
        test_simul();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
